// File: rtl/load_store_unit.sv
// Load/store initiator: turns one CPU load/store into one or two word-aligned,
// byte-enabled memory beats, with sign/zero extension of load results.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, CAPTURE, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [3:0]  be1_q, be1_d;
    logic [31:0] data0_q, data0_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]  req_bytes;
    logic [7:0]  base_mask;
    logic [7:0]  lane_mask;
    logic        req_err;
    logic [5:0]  req_sh;
    logic [31:0] wdata_rot;

    // Request decode; lane_mask spans both beats (bits 7:4 are beat 1 lanes)
    always_comb begin
        req_bytes = 3'd4;
        base_mask = 8'h0F;
        case (req_size_i)
            2'b00: begin
                req_bytes = 3'd1;
                base_mask = 8'h01;
            end
            2'b01: begin
                req_bytes = 3'd2;
                base_mask = 8'h03;
            end
            default: begin
                req_bytes = 3'd4;
                base_mask = 8'h0F;
            end
        endcase
        lane_mask = 8'(base_mask << req_addr_i[1:0]);
        req_err   = (req_size_i == 2'b11) ||
                    (({1'b0, req_addr_i} + 33'(req_bytes)) > 33'(MEM_BYTES));
        req_sh    = {req_addr_i[1:0], 3'b000};
        wdata_rot = (req_wdata_i << req_sh) | (req_wdata_i >> (6'd32 - req_sh));
    end

    logic [31:0] w0;
    logic [5:0]  ld_sh;
    logic [31:0] ld_raw;
    logic [31:0] ld_result;

    // Load assembly: beat-0 word is held in data0_q only when a second beat followed
    always_comb begin
        w0     = split_q ? data0_q : mem_rdata_i;
        ld_sh  = {off_q, 3'b000};
        ld_raw = 32'({mem_rdata_i, w0} >> ld_sh);
        case (size_q)
            2'b00:   ld_result = {{24{sgn_q & ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   ld_result = {{16{sgn_q & ld_raw[15]}}, ld_raw[15:0]};
            default: ld_result = ld_raw;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        off_d       = off_q;
        split_d     = split_q;
        be1_d       = be1_q;
        data0_d     = data0_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'd0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    sgn_d   = req_signed_i;
                    size_d  = req_size_i;
                    off_d   = req_addr_i[1:0];
                    split_d = |lane_mask[7:4];
                    be1_d   = lane_mask[7:4];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_be_d    = lane_mask[3:0];
                        mem_addr_d  = {req_addr_i[31:2], 2'b00};
                        mem_wdata_d = wdata_rot;
                    end
                end
            end
            BEAT0: begin
                if (split_q) begin
                    state_d     = BEAT1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_be_d    = be1_q;
                    mem_addr_d  = mem_addr_q + 32'd4;
                    mem_wdata_d = mem_wdata_q;
                end else if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            BEAT1: begin
                data0_d = mem_rdata_i;
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_result;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= 2'd0;
            split_q     <= 1'b0;
            be1_q       <= 4'd0;
            data0_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            off_q       <= off_d;
            split_q     <= split_d;
            be1_q       <= be1_d;
            data0_q     <= data0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory model, vector table,
// plus hand sequences for reset values and reset during a split access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_signed_i(req_signed),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: 64 bytes, read data registered one cycle after the read beat
    logic [7:0] mem [64];
    logic       mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rst_n && !mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
            mem[7]     <= 8'h34;
            mem[8]     <= 8'hF2;
            mem[13]    <= 8'h80;
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_addr < 32'd64) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) mem[mem_addr[5:0] + 6'(k)] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                              mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          nb;
        logic [31:0] rd;
        logic        er;
        logic [31:0] b_addr [2];
        logic [3:0]  b_be   [2];
        logic        b_we   [2];
        logic [31:0] b_wd   [2];
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        lat = 0;
        nb  = 0;
        rd  = 32'd0;
        er  = 1'b0;
        for (int b = 0; b < 2; b++) begin
            b_addr[b] = 32'd0; b_be[b] = 4'd0; b_we[b] = 1'b0; b_wd[b] = 32'd0;
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            // Keep presenting a different request while busy; it must be ignored
            req_we    = ~v.we;
            req_size  = 2'b10;
            req_addr  = 32'h20;
            req_wdata = 32'hCAFEF00D;
            if (c == 1) chk($sformatf("v%0d_ready_busy", idx), 32'(req_ready), 32'd0);
            if (mem_en) begin
                if (nb < 2) begin
                    b_addr[nb] = mem_addr; b_be[nb] = mem_be;
                    b_we[nb]   = mem_we;   b_wd[nb] = mem_wdata;
                end
                nb++;
            end
            if (rsp_valid) begin
                lat = c;
                rd  = rsp_rdata;
                er  = rsp_err;
                req_valid = 1'b0;
            end else begin
                chk($sformatf("v%0d_rdata_quiet", idx), rsp_rdata, 32'd0);
            end
        end
        req_valid = 1'b0;
        if (lat == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d_timeout: got no rsp_valid expected one within 20 cycles", idx);
        end else begin
            chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
            chk($sformatf("v%0d_err", idx), 32'(er), 32'(v.exp_err));
        end
        chk($sformatf("v%0d_beats", idx), 32'(nb), 32'(v.exp_beats));
        for (int b = 0; b < 2 && b < nb && b < v.exp_beats; b++) begin
            e_addr = (b == 0) ? v.a0  : v.a1;
            e_be   = (b == 0) ? v.be0 : v.be1;
            e_wd   = (b == 0) ? v.wd0 : v.wd1;
            chk($sformatf("v%0d_b%0d_addr", idx, b), b_addr[b], e_addr);
            chk($sformatf("v%0d_b%0d_be", idx, b), 32'(b_be[b]), 32'(e_be));
            chk($sformatf("v%0d_b%0d_we", idx, b), 32'(b_we[b]), 32'(v.we));
            if (v.we)
                chk($sformatf("v%0d_b%0d_wdata", idx, b), b_wd[b] & lane_bits(b_be[b]), e_wd);
        end
    endtask

    vec_t vecs [19];
    vec_t post_vec;
    logic saw_rsp;

    initial begin
        // we size sgn addr wdata | rdata err lat beats | a0 be0 wd0 | a1 be1 wd1
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'd13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1,
                     32'd12, 4'b0010, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'd13, 32'h0, 32'h00000080, 1'b0, 3, 1,
                     32'd12, 4'b0010, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'd7, 32'h0, 32'hFFFFF234, 1'b0, 4, 2,
                     32'd4, 4'b1000, 32'h0, 32'd8, 4'b0001, 32'h0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1,
                     32'd8, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1,
                     32'd8, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'd6, 32'h11223344, 32'h0, 1'b0, 3, 2,
                     32'd4, 4'b1100, 32'h33440000, 32'd8, 4'b0011, 32'h00001122};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 32'h11223344, 1'b0, 4, 2,
                     32'd4, 4'b1100, 32'h0, 32'd8, 4'b0011, 32'h0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'd8, 32'h0, 32'h00001122, 1'b0, 3, 1,
                     32'd8, 4'b0011, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'd9, 32'h0, 32'hFFFFAD11, 1'b0, 3, 1,
                     32'd8, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'd3, 32'hFFFFFFA5, 32'h0, 1'b0, 2, 1,
                     32'd0, 4'b1000, 32'hA5000000, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 32'd3, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 1,
                     32'd0, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'd62, 32'h0, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'd60, 32'h0, 32'h3F3E3D3C, 1'b0, 3, 1,
                     32'd60, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[14] = '{1'b1, 2'b01, 1'b0, 32'd63, 32'h5555, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'd63, 32'h0, 32'h0000003F, 1'b0, 3, 1,
                     32'd60, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[17] = '{1'b1, 2'b01, 1'b0, 32'd3, 32'h1234BEEF, 32'h0, 1'b0, 3, 2,
                     32'd0, 4'b1000, 32'hEF000000, 32'd4, 4'b0001, 32'h000000BE};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 32'd3, 32'h0, 32'h0000BEEF, 1'b0, 4, 2,
                     32'd0, 4'b1000, 32'h0, 32'd4, 4'b0001, 32'h0};
        post_vec = '{1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'hDEAD1122, 1'b0, 3, 1,
                     32'd8, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_mem_ctrl",  32'({mem_en, mem_we, mem_be}), 32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // Reset during BEAT1 of a split load: enables drop at once, no response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'd6;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_beat1_en", 32'(mem_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_en", 32'(mem_en), 32'd0);
        chk("midrst_async_be", 32'(mem_be), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("midrst_no_rsp", 32'(saw_rsp), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        run_vec(post_vec, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
